// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite initiator for one-word commands
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 30,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int CW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wait_state;
  logic            timeout_hit;

  assign wait_state  = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
  // cnt_q counts edges already spent in the current wait state
  assign timeout_hit = (C_TIMEOUT_CYCLES != 0) && wait_state &&
                       (cnt_q == CW'(C_TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cnt_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // slaves that re-arm only after seeing their READY fall get that chance here
        if (!(M_AXI_AWREADY || M_AXI_WREADY || M_AXI_ARREADY)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit && (state_d == state_q)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = '0;
      rsp_valid_d = 1'b1;
      state_d     = S_DONE;
    end

    if (wait_state && (state_d == state_q)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - directed and randomized bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int TMO   = 16;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]    s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;

  int total = 0;
  int bad   = 0;

  // slave behaviour knobs, set by the stimulus thread
  int aw_dly, w_dly, b_dly, ar_dly, r_dly, ar_linger;
  logic [1:0]    cfg_bresp, cfg_rresp;
  logic [DW-1:0] cfg_rdata;

  // slave observations
  logic [AW-1:0] log_awaddr, log_araddr;
  logic [DW-1:0] log_wdata;
  logic [SW-1:0] log_wstrb;
  int n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_r_hs = 0;
  int n_awv, n_wv, n_arv, n_bready, stab_err;

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_TIMEOUT_CYCLES  (TMO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .M_AXI_AWADDR (M_AXI_AWADDR),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA  (M_AXI_WDATA),
    .M_AXI_WSTRB  (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID),
    .M_AXI_WREADY (s_wready),
    .M_AXI_BRESP  (s_bresp),
    .M_AXI_BVALID (s_bvalid),
    .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA  (s_rdata),
    .M_AXI_RRESP  (s_rresp),
    .M_AXI_RVALID (s_rvalid),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // acceptance cycle counts as 1; each READY/response delay adds its cycles
  function automatic int model_lat(input bit wr);
    if (wr) return 4 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    return 4 + ar_dly + r_dly;
  endfunction

  // AXI-Lite slave responder, evaluated on the falling edge
  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit aw_done, w_done, b_pend, r_pend;
    bit p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;
    int aw_held, w_held, ar_held, b_wait, r_wait, ar_lin;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
    s_bresp = 2'b01; s_rresp = 2'b01; s_rdata = 32'hDEAD_BEEF;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    aw_held = 0; w_held = 0; ar_held = 0; b_wait = 0; r_wait = 0; ar_lin = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        aw_held = 0; w_held = 0; ar_held = 0; ar_lin = 0;
      end else begin
        hs_aw = p_awv && s_awready;
        hs_w  = p_wv && s_wready;
        hs_ar = p_arv && s_arready;
        hs_b  = s_bvalid && p_bready;
        hs_r  = s_rvalid && p_rready;
        if (p_awv && !hs_aw && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) stab_err++;
        if (p_wv && !hs_w && (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata || M_AXI_WSTRB !== p_wstrb)) stab_err++;
        if (p_arv && !hs_ar && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) stab_err++;
        if (hs_aw) begin aw_done = 1; log_awaddr = p_awaddr; n_aw_hs++; end
        if (hs_w) begin w_done = 1; log_wdata = p_wdata; log_wstrb = p_wstrb; n_w_hs++; end
        if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_pend = 1; b_wait = 0; end
        if (hs_b) begin s_bvalid = 0; s_bresp = 2'b01; b_pend = 0; n_b_hs++; end
        if (b_pend && !s_bvalid) begin
          if (b_wait >= b_dly) begin s_bvalid = 1; s_bresp = cfg_bresp; end
          b_wait++;
        end
        if (hs_ar) begin r_pend = 1; r_wait = 0; log_araddr = p_araddr; n_ar_hs++; ar_lin = ar_linger; end
        if (hs_r) begin s_rvalid = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01; r_pend = 0; n_r_hs++; end
        if (r_pend && !s_rvalid) begin
          if (r_wait >= r_dly) begin s_rvalid = 1; s_rdata = cfg_rdata; s_rresp = cfg_rresp; end
          r_wait++;
        end
        if (M_AXI_AWVALID) begin s_awready = (aw_held >= aw_dly); aw_held++; end
        else begin s_awready = 0; aw_held = 0; end
        if (M_AXI_WVALID) begin s_wready = (w_held >= w_dly); w_held++; end
        else begin s_wready = 0; w_held = 0; end
        if (M_AXI_ARVALID) begin s_arready = (ar_held >= ar_dly); ar_held++; end
        else if (ar_lin > 0) begin s_arready = 1; ar_lin--; ar_held = 0; end
        else begin s_arready = 0; ar_held = 0; end
        if (M_AXI_AWVALID) n_awv++;
        if (M_AXI_WVALID) n_wv++;
        if (M_AXI_ARVALID) n_arv++;
        if (M_AXI_BREADY) n_bready++;
        p_awv = M_AXI_AWVALID; p_wv = M_AXI_WVALID; p_arv = M_AXI_ARVALID;
        p_awaddr = M_AXI_AWADDR; p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        p_araddr = M_AXI_ARADDR; p_bready = M_AXI_BREADY; p_rready = M_AXI_RREADY;
      end
    end
  end

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r, input int lin);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; ar_linger = lin;
  endtask

  // called on a falling edge; returns on the falling edge where rsp_valid is first seen
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output int lat);
    int n;
    n_awv = 0; n_wv = 0; n_arv = 0; n_bready = 0; stab_err = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 2;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
  endtask

  task automatic run_cmd(input string tag, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    int lat, exp_lat, aw0, w0, b0, ar0, r0;
    logic [1:0] exp_resp;
    logic [DW-1:0] exp_rdata;
    exp_lat   = model_lat(wr);
    exp_resp  = wr ? cfg_bresp : cfg_rresp;
    exp_rdata = wr ? '0 : cfg_rdata;
    aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b_hs; ar0 = n_ar_hs; r0 = n_r_hs;
    issue(wr, a, d, s, lat);
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({tag, ".resp"}, 64'(rsp_resp), 64'(exp_resp));
    @(negedge clk);
    check({tag, ".pulse"}, 64'(rsp_valid), 64'(0));
    if (wr) begin
      check({tag, ".awaddr"}, 64'(log_awaddr), 64'(a));
      check({tag, ".wdata"}, 64'(log_wdata), 64'(d));
      check({tag, ".wstrb"}, 64'(log_wstrb), 64'(s));
      check({tag, ".hs"}, 64'({n_aw_hs - aw0, n_w_hs - w0, n_b_hs - b0}), 64'({32'd1, 32'd1, 32'd1}));
      check({tag, ".awv_cyc"}, 64'(n_awv), 64'(aw_dly + 1));
      check({tag, ".wv_cyc"}, 64'(n_wv), 64'(w_dly + 1));
      check({tag, ".bready_cyc"}, 64'(n_bready), 64'(b_dly + 1));
    end else begin
      check({tag, ".araddr"}, 64'(log_araddr), 64'(a));
      check({tag, ".hs"}, 64'({n_ar_hs - ar0, n_r_hs - r0}), 64'({32'd1, 32'd1}));
      check({tag, ".arv_cyc"}, 64'(n_arv), 64'(ar_dly + 1));
    end
    check({tag, ".stable"}, 64'(stab_err), 64'(0));
  endtask

  initial begin
    int lat, n, busy_rdy, gap, seen;
    logic [DW-1:0] rd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    set_dly(0, 0, 0, 0, 0, 0);
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
    n_awv = 0; n_wv = 0; n_arv = 0; n_bready = 0; stab_err = 0;
    repeat (3) @(negedge clk);
    check("reset.handshakes", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    check("reset.rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'(0));
    check("reset.addr", 64'({M_AXI_AWADDR, M_AXI_WSTRB}), 64'(0));
    check("reset.cmd_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b0;
    @(negedge clk);

    run_cmd("wr_basic", 1'b1, 30'h0000_000C, 32'h0000_0064, 4'hF);

    set_dly(0, 0, 0, 3, 0, 0);
    cfg_rdata = 32'h0000_0002;
    run_cmd("rd_arlate", 1'b0, 30'h0000_0000, 32'h0, 4'h0);

    set_dly(2, 0, 1, 0, 0, 0);
    cfg_bresp = 2'b01;
    run_cmd("wr_w_first", 1'b1, 30'h0000_0040, 32'h1234_5678, 4'h5);
    set_dly(0, 2, 0, 0, 0, 0);
    cfg_bresp = 2'b00;
    run_cmd("wr_aw_first", 1'b1, 30'h0000_0044, 32'h8765_4321, 4'hA);

    set_dly(0, 0, 0, 0, 0, 3);
    cfg_rdata = 32'hCAFE_F00D;
    issue(1'b0, 30'h0000_0080, 32'h0, 4'h0, lat);
    check("linger.lat", 64'(lat), 64'(model_lat(1'b0)));
    gap = 0;
    while (!cmd_ready && gap < 20) begin @(negedge clk); gap++; end
    check("linger.done_hold", 64'(gap), 64'(3));
    set_dly(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    cfg_rresp = 2'b10; cfg_bresp = 2'b00; cfg_rdata = 32'h0BAD_0001;
    cmd_write = 1'b0; cmd_addr = 30'h0000_0100; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 30'h0000_0104; cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
    busy_rdy = 0; lat = 2;
    while (!rsp_valid && lat < 100) begin
      if (cmd_ready) busy_rdy++;
      @(negedge clk); lat++;
    end
    check("b2b.rd_lat", 64'(lat), 64'(4));
    check("b2b.rd_resp", 64'(rsp_resp), 64'(2'b10));
    check("b2b.rd_data", 64'(rsp_rdata), 64'(32'h0BAD_0001));
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("b2b.idle_gap", 64'(n), 64'(1));
    check("b2b.busy_ready", 64'(busy_rdy), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0; lat = 2;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    check("b2b.wr_lat", 64'(lat), 64'(4));
    check("b2b.wr_rsp", 64'({rsp_resp, rsp_rdata}), 64'(0));
    @(negedge clk);
    check("b2b.wr_bus", 64'({log_awaddr, log_wstrb}), 64'({30'h0000_0104, 4'h3}));
    cfg_rresp = 2'b00;

    for (int i = 0; i < 24; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      cfg_bresp = 2'($urandom_range(0, 3));
      cfg_rresp = 2'($urandom_range(0, 3));
      rd = $urandom;
      cfg_rdata = rd;
      run_cmd($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 30'($urandom), 32'($urandom), 4'($urandom));
    end

    set_dly(0, 0, NEVER, 0, 0, 0);
    issue(1'b1, 30'h3FFF_FFFC, 32'hFEED_0000, 4'hF, lat);
    check("tmo.lat", 64'(lat), 64'(3 + TMO));
    check("tmo.resp", 64'(rsp_resp), 64'(2'b11));
    check("tmo.rdata", 64'(rsp_rdata), 64'(0));
    check("tmo.bready", 64'(M_AXI_BREADY), 64'(0));
    check("tmo.bready_cyc", 64'(n_bready), 64'(TMO));
    @(negedge clk);
    check("tmo.idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));

    r_dly = NEVER;
    cmd_write = 1'b0; cmd_addr = 30'h0000_0200; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!M_AXI_RREADY && n < 20) begin @(negedge clk); n++; end
    check("rst.in_rd_resp", 64'(M_AXI_RREADY), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst.handshakes", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    check("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    set_dly(0, 0, 0, 0, 0, 0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    check("rst.no_rsp", 64'(seen), 64'(0));
    check("rst.cmd_ready", 64'(cmd_ready), 64'(1));
    cfg_bresp = 2'b00;
    run_cmd("post_rst", 1'b1, 30'h0000_0300, 32'h0000_00AB, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
